// File: rtl/p405s_trc_pkg.sv
// Shared sizing and types for the parametrised trace FIFO.
// Optional feature macro used by the top: P405S_TRC_FIFO_AFULL_EN.
package p405s_trc_pkg;

  localparam int TRC_DATA_W = 32;
  localparam int TRC_DEPTH  = 16;
  localparam int TRC_PTR_W  = $clog2(TRC_DEPTH);
  localparam int TRC_CNT_W  = TRC_PTR_W + 1;

  typedef logic [TRC_DATA_W-1:0] trc_entry_t;

endpackage

// File: rtl/p405s_trc_fifo_ram.sv
// Trace FIFO storage: DEPTH x DATA_W flop array, one enabled write port,
// asynchronous read port. Contents are deliberately not reset.
module p405s_trc_fifo_ram
  import p405s_trc_pkg::*;
#(
  parameter int DATA_W = TRC_DATA_W,
  parameter int DEPTH  = TRC_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/p405s_trc_fifo_gen.sv
// Parametrised trace FIFO with stop-on-full / wrap modes, sticky overflow and FWFT output.
// Define P405S_TRC_FIFO_AFULL_EN to add the registered almost-full output trcFifoAFull.
module p405s_trc_fifo_gen
  import p405s_trc_pkg::*;
#(
  parameter int DATA_W = TRC_DATA_W,
  parameter int DEPTH  = TRC_DEPTH
`ifdef P405S_TRC_FIFO_AFULL_EN
  ,
  parameter int AF_LVL = 12
`endif
) (
  input  logic                   CB,
  input  logic                   trcReset,
  input  logic [DATA_W-1:0]      trcFifoDataIn,
  input  logic                   trcFifoPush,
  input  logic                   trcFifoPop,
  input  logic                   trcWrapMode,
  input  logic                   trcFifoFlush,
  input  logic                   trcOvfClr,
  output logic [DATA_W-1:0]      trcFifoDataOut,
  output logic                   trcFifoEmpty,
  output logic                   trcFifoFull,
  output logic [$clog2(DEPTH):0] trcFifoCount,
`ifdef P405S_TRC_FIFO_AFULL_EN
  output logic                   trcFifoAFull,
`endif
  output logic                   trcFifoOvf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             empty, full, pop_ok, ovf_set, we;
  logic [DATA_W-1:0] rdata;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == FULL_CNT);
  assign pop_ok = trcFifoPop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_set  = 1'b0;
    we       = 1'b0;
    if (trcFifoFlush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else if (trcFifoPush) begin
      // When full, a push only lands if a pop frees the slot or wrap overwrites the oldest.
      if (!full || pop_ok || trcWrapMode) begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (full) begin
        if (pop_ok || trcWrapMode) rd_ptr_d = rd_ptr_q + 1'b1;
        if (!pop_ok) ovf_set = 1'b1;
      end else if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d    = cnt_q - 1'b1;
    end
    ovf_d = ovf_set | (ovf_q & ~trcOvfClr);
  end

  always_ff @(posedge CB) begin
    if (trcReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef P405S_TRC_FIFO_AFULL_EN
  logic afull_q;

  always_ff @(posedge CB) begin
    if (trcReset) afull_q <= 1'b0;
    else          afull_q <= (int'(cnt_d) >= AF_LVL);
  end

  assign trcFifoAFull = afull_q;
`endif

  p405s_trc_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk_i   (CB),
    .we_i    (we && !trcReset),
    .waddr_i (wr_ptr_q),
    .wdata_i (trcFifoDataIn),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign trcFifoDataOut = empty ? '0 : rdata;
  assign trcFifoEmpty   = empty;
  assign trcFifoFull    = full;
  assign trcFifoCount   = cnt_q;
  assign trcFifoOvf     = ovf_q;

endmodule
